// File: rtl/fx3_packet_streamer_pkg.sv
// Shared definitions for the FX3 packet streamer and its upstream FIFO stage.
// The default packet size is also the threshold upstream uses to raise
// dataAvailable, so both sides stay consistent.
package fx3_packet_streamer_pkg;

    localparam int DEFAULT_PACKET_WORDS = 8192;
    localparam int DEFAULT_READ_LATENCY = 2;
    localparam int SAMPLE_W             = 16;
    localparam int PACKET_COUNT_W       = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_DRAIN = 2'd2,
        ST_HALT  = 2'd3
    } stream_state_t;

    // Completed-packet counter advance; wraps from all-ones to zero.
    function automatic logic [PACKET_COUNT_W-1:0] next_packet_count(
        input logic [PACKET_COUNT_W-1:0] count
    );
        return count + PACKET_COUNT_W'(1);
    endfunction

endpackage

// File: rtl/fx3_packet_streamer_read_align.sv
// Valid/last delay line matching the FIFO + conversion read latency.
// A read request entering here emerges STAGES cycles later, exactly when the
// corresponding sample is present on dataIn. A synchronous clear drops every
// word in flight so that an aborted packet never reaches the FX3 bus.
module read_align_pipe #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic vld_in,
    input  logic last_in,
    output logic vld_out,
    output logic last_out
);

    logic [STAGES-1:0] vld_p;
    logic [STAGES-1:0] last_p;

    // Shift the read tags forward one stage per cycle; clear empties the pipe.
    always_ff @(posedge clk) begin
        if (!reset_n || clear) begin
            vld_p  <= '0;
            last_p <= '0;
        end else begin
            vld_p[0]  <= vld_in;
            last_p[0] <= last_in & vld_in;
            for (int i = 1; i < STAGES; i++) begin
                vld_p[i]  <= vld_p[i-1];
                last_p[i] <= last_p[i-1];
            end
        end
    end

    assign vld_out  = vld_p[STAGES-1];
    assign last_out = last_p[STAGES-1];

endmodule

// File: rtl/fx3_packet_streamer.sv
// FX3 packet streamer: waits for a full packet in the sample FIFO and a free
// FX3 DMA buffer, then drains exactly one packet onto the GPIF bus with a
// contiguous write strobe and an end-of-packet flag on the final word.
// A buffer error while capturing aborts the packet without an end flag.
module fx3_packet_streamer
    import fx3_packet_streamer_pkg::*;
#(
    parameter int PACKET_WORDS = DEFAULT_PACKET_WORDS,
    parameter int READ_LATENCY = DEFAULT_READ_LATENCY
) (
    input  logic                      fx3Clk,
    input  logic                      nReset,
    input  logic                      collectData,
    input  logic                      dataAvailable,
    input  logic                      bufferError,
    input  logic                      fx3Ready,
    input  logic [SAMPLE_W-1:0]       dataIn,
    output logic                      readData,
    output logic                      fx3Write,
    output logic                      fx3EndPacket,
    output logic [SAMPLE_W-1:0]       fx3Data,
    output logic                      streaming,
    output logic [PACKET_COUNT_W-1:0] packetCount
);

    localparam int               CNT_W     = $clog2(PACKET_WORDS);
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(PACKET_WORDS - 1);

    stream_state_t               state;
    stream_state_t               state_next;
    logic [CNT_W-1:0]            word_count;
    logic                        start_req;
    logic                        halt_req;
    logic                        burst_last;
    logic                        align_vld;
    logic                        align_last;
    logic                        write_p1;
    logic                        end_p1;
    logic signed [SAMPLE_W-1:0]  sample_p1;
    logic [PACKET_COUNT_W-1:0]   packet_count;

    // fx3Ready is only consulted here: the FX3 buffer always holds a whole packet.
    assign start_req  = collectData & dataAvailable & fx3Ready & ~bufferError;
    assign halt_req   = bufferError & collectData;
    assign burst_last = (state == ST_BURST) && (word_count == LAST_WORD);

    // State register.
    always_ff @(posedge fx3Clk) begin
        if (!nReset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode; read request and streaming flag come from the current state.
    always_comb begin
        state_next = state;
        readData   = 1'b0;
        streaming  = 1'b0;
        if (halt_req) begin
            state_next = ST_HALT;
        end else begin
            case (state)
                ST_IDLE:  if (start_req)    state_next = ST_BURST;
                ST_BURST: if (burst_last)   state_next = ST_DRAIN;
                ST_DRAIN: if (end_p1)       state_next = ST_IDLE;
                ST_HALT:  if (!collectData) state_next = ST_IDLE;
                default:                    state_next = ST_IDLE;
            endcase
        end
        readData  = (state == ST_BURST);
        streaming = (state == ST_BURST) || (state == ST_DRAIN);
    end

    // Word counter: counts reads within the burst, parked at zero elsewhere.
    always_ff @(posedge fx3Clk) begin
        if (!nReset) begin
            word_count <= '0;
        end else if (state != ST_BURST) begin
            word_count <= '0;
        end else begin
            word_count <= word_count + CNT_W'(1);
        end
    end

    // Stage p0: read tags travel alongside the FIFO latency.
    read_align_pipe #(
        .STAGES (READ_LATENCY)
    ) u_read_align (
        .clk      (fx3Clk),
        .reset_n  (nReset),
        .clear    (halt_req),
        .vld_in   (readData),
        .last_in  (burst_last),
        .vld_out  (align_vld),
        .last_out (align_last)
    );

    // Stage p1: register the arriving sample and its strobes onto the GPIF bus.
    always_ff @(posedge fx3Clk) begin
        if (!nReset) begin
            write_p1  <= 1'b0;
            end_p1    <= 1'b0;
            sample_p1 <= '0;
        end else begin
            write_p1 <= align_vld & ~halt_req;
            end_p1   <= align_vld & align_last & ~halt_req;
            if (align_vld && !halt_req) begin
                sample_p1 <= $signed(dataIn);
            end
        end
    end

    // Completed-packet counter, advanced while the end flag is on the bus.
    always_ff @(posedge fx3Clk) begin
        if (!nReset) begin
            packet_count <= '0;
        end else if (end_p1) begin
            packet_count <= next_packet_count(packet_count);
        end
    end

    assign fx3Write     = write_p1;
    assign fx3EndPacket = end_p1;
    assign fx3Data      = sample_p1;
    assign packetCount  = packet_count;

endmodule
